// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom AXI IP register-to-hardware path:
// FSM status encoding, the engine opcode set and the opcode width.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_PASS = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_ACC  = 2'd3
  } op_e;

endpackage

// File: rtl/custom_axi_ip_sync_fifo.sv
// Single-clock FIFO used as the engine's input buffer.
// Push is ignored when full and pop is ignored when empty; rdata_o always
// shows the head entry, so a pop consumes exactly what is on rdata_o.
module custom_axi_ip_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Next pointer and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/custom_axi_ip_mc_engine.sv
// Multi-channel data-processing engine. Buffers {op, ch, data} words in an
// input FIFO, processes one at a time (PASS/INC/DEC/per-channel ACC) and
// returns each result over a valid/ready output.
// Optional build macro: CUSTOM_AXI_IP_MC_SAT_EN -- INC/ACC clamp to all-ones
// on carry and DEC clamps to zero on borrow (accumulator keeps the clamped
// value, out_ovf_o still flags). Without it results wrap.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready_o does not depend on in_valid_i; out_valid_o, once high,
// stays high with data/ch/ovf stable until the edge where out_ready_i is 1.
module custom_axi_ip_mc_engine
  import custom_axi_ip_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_CH     = 2,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(1),
  localparam int                 CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [CH_W-1:0]       in_ch_i,
  input  logic [OP_W-1:0]       in_op_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CH_W-1:0]       out_ch_o,
  output logic                  out_ovf_o,
  output status_e               status_o,
  output logic [7:0]            err_count_o
);

  localparam int          FW       = OP_W + CH_W + DATA_WIDTH;
  localparam logic [4:0]  NUM_CH_L = 5'(NUM_CH);

  // Input buffer
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]   fifo_wdata, fifo_rdata;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CH_W-1:0]       head_ch;
  logic [OP_W-1:0]       head_op;
  logic                  head_legal;

  assign fifo_push  = in_valid_i && !fifo_full;
  assign in_ready_o = !fifo_full;
  assign fifo_wdata = {in_op_i, in_ch_i, in_data_i};
  assign {head_op, head_ch, head_data} = fifo_rdata;
  // Channel check done on a 5-bit zero-extended copy so NUM_CH == 2^CH_W still compares correctly.
  assign head_legal = (5'(head_ch) < NUM_CH_L);

  custom_axi_ip_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State, operand, result and accumulator registers
  status_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
  logic [CH_W-1:0]       op_ch_q, op_ch_d;
  op_e                   op_op_q, op_op_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]       res_ch_q, res_ch_d;
  logic                  res_ovf_q, res_ovf_d;
  logic [7:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] acc_q [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_d [NUM_CH];

  logic [DATA_WIDTH-1:0] acc_sel;
  logic [DATA_WIDTH:0]   calc_ext;
  logic [DATA_WIDTH-1:0] calc_data;
  logic                  calc_ovf;
  logic                  take;

  assign out_valid_o = (state_q == ST_DONE);
  assign out_data_o  = res_data_q;
  assign out_ch_o    = res_ch_q;
  assign out_ovf_o   = res_ovf_q;
  assign status_o    = state_q;
  assign err_count_o = err_q;

  // Arithmetic datapath on the operand registers; carry/borrow is the extra top bit.
  always_comb begin
    acc_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (op_ch_q == CH_W'(c)) acc_sel = acc_q[c];
    end
    calc_ext = {1'b0, op_data_q};
    case (op_op_q)
      OP_INC:  calc_ext = {1'b0, op_data_q} + {1'b0, STEP};
      OP_DEC:  calc_ext = {1'b0, op_data_q} - {1'b0, STEP};
      OP_ACC:  calc_ext = {1'b0, acc_sel} + {1'b0, op_data_q};
      default: calc_ext = {1'b0, op_data_q};
    endcase
    calc_ovf  = calc_ext[DATA_WIDTH];
    calc_data = calc_ext[DATA_WIDTH-1:0];
`ifdef CUSTOM_AXI_IP_MC_SAT_EN
    if (calc_ovf) calc_data = (op_op_q == OP_DEC) ? '0 : '1;
`endif
  end

  // FSM next state: fetch from the FIFO, compute, present, or drop an illegal-channel word.
  always_comb begin
    state_d    = state_q;
    op_data_d  = op_data_q;
    op_ch_d    = op_ch_q;
    op_op_d    = op_op_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    res_ovf_d  = res_ovf_q;
    err_d      = err_q;
    acc_d      = acc_q;
    take       = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) take = 1'b1;
      end
      ST_BUSY: begin
        res_data_d = calc_data;
        res_ch_d   = op_ch_q;
        res_ovf_d  = calc_ovf;
        if (op_op_q == OP_ACC) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (op_ch_q == CH_W'(c)) acc_d[c] = calc_data;
          end
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) begin
          if (!fifo_empty) take = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head word into the operand registers.
    if (take) begin
      fifo_pop  = 1'b1;
      op_data_d = head_data;
      op_ch_d   = head_ch;
      op_op_d   = op_e'(head_op);
      state_d   = head_legal ? ST_BUSY : ST_ERROR;
    end
  end

  // Register update; reset returns to IDLE with zeroed results, counters and accumulators.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_data_q  <= '0;
      op_ch_q    <= '0;
      op_op_q    <= OP_PASS;
      res_data_q <= '0;
      res_ch_q   <= '0;
      res_ovf_q  <= 1'b0;
      err_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      op_data_q  <= op_data_d;
      op_ch_q    <= op_ch_d;
      op_op_q    <= op_op_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
      res_ovf_q  <= res_ovf_d;
      err_q      <= err_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_mc_engine.sv
// Bench for custom_axi_ip_mc_engine: a default instance (NUM_CH=2) and a
// NUM_CH=3 instance share clock, reset and output-ready; sel steers the
// input stream to one of them. Expected results are queued when a word is
// accepted and a monitor compares them as each result is handed off.
module tb_custom_axi_ip_mc_engine;
  import custom_axi_ip_pkg::*;

  localparam int DW = 32;
  localparam int EW = DW + 2 + 1;

`ifdef CUSTOM_AXI_IP_MC_SAT_EN
  localparam logic [DW-1:0] INC_TOP_RES = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] DEC_BOT_RES = 32'h0000_0000;
  localparam logic [DW-1:0] ACC_TOP_RES = 32'hFFFF_FFFF;
`else
  localparam logic [DW-1:0] INC_TOP_RES = 32'h0000_0000;
  localparam logic [DW-1:0] DEC_BOT_RES = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] ACC_TOP_RES = 32'h0000_0006;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic          sel;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    in_ch;
  logic [1:0]    in_op;
  logic          out_ready;

  logic          a_in_ready, a_out_valid, a_out_ovf;
  logic [DW-1:0] a_out_data;
  logic [0:0]    a_out_ch;
  status_e       a_status;
  logic [7:0]    a_err;

  logic          b_in_ready, b_out_valid, b_out_ovf;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_out_ch;
  status_e       b_status;
  logic [7:0]    b_err;

  logic          m_in_ready, m_valid, m_ovf;
  logic [DW-1:0] m_data;
  logic [1:0]    m_ch;

  assign m_in_ready = sel ? b_in_ready  : a_in_ready;
  assign m_valid    = sel ? b_out_valid : a_out_valid;
  assign m_data     = sel ? b_out_data  : a_out_data;
  assign m_ch       = sel ? b_out_ch    : {1'b0, a_out_ch};
  assign m_ovf      = sel ? b_out_ovf   : a_out_ovf;

  custom_axi_ip_mc_engine u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid && !sel),
    .in_ready_o  (a_in_ready),
    .in_data_i   (in_data),
    .in_ch_i     (in_ch[0:0]),
    .in_op_i     (in_op),
    .out_valid_o (a_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (a_out_data),
    .out_ch_o    (a_out_ch),
    .out_ovf_o   (a_out_ovf),
    .status_o    (a_status),
    .err_count_o (a_err)
  );

  custom_axi_ip_mc_engine #(.NUM_CH(3)) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid && sel),
    .in_ready_o  (b_in_ready),
    .in_data_i   (in_data),
    .in_ch_i     (in_ch),
    .in_op_i     (in_op),
    .out_valid_o (b_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (b_out_data),
    .out_ch_o    (b_out_ch),
    .out_ovf_o   (b_out_ovf),
    .status_o    (b_status),
    .err_count_o (b_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int err_cycles = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a result is handed off at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && m_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%h ch=%0d ovf=%0d", m_data, m_ch, m_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({m_data, m_ch, m_ovf} !== e) begin
          errors++;
          $display("FAIL result got data=%h ch=%0d ovf=%0d expected data=%h ch=%0d ovf=%0d",
                   m_data, m_ch, m_ovf, e[EW-1:3], e[2:1], e[0]);
        end
      end
    end
  end

  // Count cycles the NUM_CH=3 instance spends in ERROR.
  always @(negedge clk) begin
    if (!rst && b_status == ST_ERROR) err_cycles++;
  end

  // ---------------- driver tasks ----------------
  // Present one word and hold it until accepted. Called just after a rising edge.
  task automatic send(input logic s, input logic [1:0] op, input logic [1:0] ch,
                      input logic [DW-1:0] d, input logic expect_out,
                      input logic [DW-1:0] ed, input logic eo);
    int n;
    n = 0;
    sel = s; in_op = op; in_ch = ch; in_data = d; in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!m_in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected in_ready=1");
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    if (expect_out) exp_q.push_back({ed, ch, eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for every queued result to be seen, bounded.
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d expected pending=0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int accepted;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_a_status",    32'(a_status),    32'(ST_IDLE));
    check("rst_a_err",       32'(a_err),       32'd0);
    check("rst_a_out_data",  a_out_data,       32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_status",    32'(b_status),    32'(ST_IDLE));
    @(posedge clk); #1;

    // 1. INC 5 on ch0: latency and status sequence
    out_ready = 1'b1;
    send(1'b0, OP_INC, 2'd0, 32'h5, 1'b1, 32'h6, 1'b0);
    @(negedge clk);
    check("lat_n_status",  32'(a_status), 32'(ST_IDLE));
    check("lat_n_valid",   32'(a_out_valid), 32'd0);
    @(negedge clk);
    check("lat_n1_status", 32'(a_status), 32'(ST_BUSY));
    check("lat_n1_valid",  32'(a_out_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_status", 32'(a_status), 32'(ST_DONE));
    check("lat_n2_valid",  32'(a_out_valid), 32'd1);
    @(negedge clk);
    check("lat_n3_status", 32'(a_status), 32'(ST_IDLE));
    @(posedge clk); #1;
    wait_drain();

    // 2. Boundary arithmetic, PASS and plain DEC
    send(1'b0, OP_INC,  2'd0, 32'hFFFF_FFFF, 1'b1, INC_TOP_RES,  1'b1);
    send(1'b0, OP_DEC,  2'd1, 32'h0000_0000, 1'b1, DEC_BOT_RES,  1'b1);
    send(1'b0, OP_DEC,  2'd0, 32'h0000_0010, 1'b1, 32'h0000_000F, 1'b0);
    send(1'b0, OP_PASS, 2'd1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_drain();

    // 3. Per-channel accumulation, including a carry on ch0
    send(1'b0, OP_ACC, 2'd1, 32'd10, 1'b1, 32'd10, 1'b0);
    send(1'b0, OP_ACC, 2'd1, 32'd20, 1'b1, 32'd30, 1'b0);
    send(1'b0, OP_ACC, 2'd0, 32'd7,  1'b1, 32'd7,  1'b0);
    send(1'b0, OP_ACC, 2'd0, 32'hFFFF_FFFF, 1'b1, ACC_TOP_RES, 1'b1);
    send(1'b0, OP_ACC, 2'd0, 32'd0,  1'b1, ACC_TOP_RES, 1'b0);
    send(1'b0, OP_ACC, 2'd1, 32'd0,  1'b1, 32'd30, 1'b0);
    wait_drain();

    // 4. Backpressure: six back-to-back words with out_ready low
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      sel = 1'b0; in_valid = 1'b1; in_op = OP_INC;
      in_ch = 2'(i % 2); in_data = 32'(100 + i);
      @(negedge clk);
      if (i == 5) check("full_in_ready", 32'(m_in_ready), 32'd0);
      if (m_in_ready) begin
        accepted++;
        exp_q.push_back({32'(101 + i), 2'(i % 2), 1'b0});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accepted_count", 32'(accepted), 32'd5);
    out_ready = 1'b1;
    wait_drain();

    // 5. Illegal channel on the NUM_CH=3 instance
    err_cycles = 0;
    send(1'b1, OP_INC, 2'd3, 32'h55, 1'b0, 32'h0, 1'b0);
    send(1'b1, OP_INC, 2'd2, 32'h1,  1'b1, 32'h2, 1'b0);
    wait_drain();
    check("error_cycles", 32'(err_cycles), 32'd1);
    check("err_count",    32'(b_err),      32'd1);
    check("err_status",   32'(b_status),   32'(ST_IDLE));
    sel = 1'b0;

    // 6. Reset while presenting a result with two words queued
    out_ready = 1'b0;
    send(1'b0, OP_PASS, 2'd0, 32'h1, 1'b1, 32'h1, 1'b0);
    send(1'b0, OP_PASS, 2'd1, 32'h2, 1'b1, 32'h2, 1'b0);
    send(1'b0, OP_PASS, 2'd0, 32'h3, 1'b1, 32'h3, 1'b0);
    @(negedge clk);
    check("pre_rst_status", 32'(a_status), 32'(ST_DONE));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_valid",    32'(a_out_valid), 32'd0);
    check("post_rst_status",   32'(a_status),    32'(ST_IDLE));
    check("post_rst_in_ready", 32'(a_in_ready),  32'd1);
    check("post_rst_b_err",    32'(b_err),       32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(1'b0, OP_ACC, 2'd1, 32'd5, 1'b1, 32'd5, 1'b0);
    send(1'b0, OP_ACC, 2'd0, 32'd3, 1'b1, 32'd3, 1'b0);
    wait_drain();

    check("final_a_err",   32'(a_err),          32'd0);
    check("final_pending", 32'(exp_q.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
